// File: rtl/arb_mux2_pkg.sv
// Shared types for the two-input packet arbiter: FSM state encoding and grant values.
package arb_mux2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam logic GRANT_I0 = 1'b0;
  localparam logic GRANT_I1 = 1'b1;

  // Lock state entered after a non-last beat from the given input.
  function automatic arb_state_e lock_state(input logic grant);
    return (grant == GRANT_I1) ? LOCK1 : LOCK0;
  endfunction

endpackage

// File: rtl/commonlib_muxn.sv
// Generic N:1 combinational mux; zero latency, no flow control.
// An out-of-range select on non-power-of-two N yields all zeros.
module commonlib_muxn #(
  parameter int N  = 2,
  parameter int W  = 1,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0][W-1:0] in_i,
  input  logic [SW-1:0]       sel_i,
  output logic [W-1:0]        out_o
);

  always_comb begin
    out_o = '0;
    if (int'(sel_i) < N) begin
      out_o = in_i[sel_i];
    end
  end

endmodule

// File: rtl/arb_mux2_stream.sv
// Round-robin 2:1 packet arbiter with a registered output beat; one cycle accept-to-valid.
// Backpressure: both readys drop while the output register is full and O_ready is low.
module arb_mux2_stream
  import arb_mux2_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I0_data,
  input  logic             I0_last,
  input  logic             I0_valid,
  output logic             I0_ready,
  input  logic [WIDTH-1:0] I1_data,
  input  logic             I1_last,
  input  logic             I1_valid,
  output logic             I1_ready,
  output logic [WIDTH-1:0] O_data,
  output logic             O_last,
  output logic             O_valid,
  input  logic             O_ready,
  output logic             S
);

  arb_state_e       state_q, state_d;
  logic             prio_q, prio_d;
  logic             s_q;
  logic             o_valid_q, o_valid_d;
  logic [WIDTH-1:0] o_data_q, o_data_d;
  logic             o_last_q, o_last_d;

  logic             grant;
  logic             load;
  logic             accept;
  logic [1:0][WIDTH:0] mux_in;
  logic [WIDTH:0]   mux_out;

  // Idle with no requester keeps the previous select so the mux does not glitch.
  always_comb begin
    grant = s_q;
    case (state_q)
      IDLE: begin
        if (I0_valid && I1_valid) grant = prio_q;
        else if (I0_valid)        grant = GRANT_I0;
        else if (I1_valid)        grant = GRANT_I1;
      end
      LOCK0:   grant = GRANT_I0;
      LOCK1:   grant = GRANT_I1;
      default: grant = s_q;
    endcase
  end

  assign load     = !o_valid_q || O_ready;
  assign I0_ready = ASYNCRESETN && load && (grant == GRANT_I0);
  assign I1_ready = ASYNCRESETN && load && (grant == GRANT_I1);
  assign accept   = (I0_valid && I0_ready) || (I1_valid && I1_ready);

  assign mux_in[0] = {I0_data, I0_last};
  assign mux_in[1] = {I1_data, I1_last};

  commonlib_muxn #(
    .N (2),
    .W (WIDTH + 1)
  ) u_sel_mux (
    .in_i  (mux_in),
    .sel_i (grant),
    .out_o (mux_out)
  );

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    if (accept) begin
      o_valid_d = 1'b1;
      o_data_d  = mux_out[WIDTH:1];
      o_last_d  = mux_out[0];
      if (mux_out[0]) begin
        state_d = IDLE;
        prio_d  = ~grant;
      end else begin
        state_d = lock_state(grant);
      end
    end else if (O_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q   <= IDLE;
      prio_q    <= GRANT_I0;
      s_q       <= GRANT_I0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      s_q       <= grant;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
    end
  end

  assign O_valid = o_valid_q;
  assign O_data  = o_data_q;
  assign O_last  = o_last_q;
  assign S       = grant;

endmodule

// File: tb/tb_arb_mux2_stream.sv
// Directed bench for arb_mux2_stream (WIDTH=4) with hand-computed expectations.
module tb_arb_mux2_stream;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] i0_data, i1_data, o_data;
  logic         i0_last, i0_valid, i0_ready;
  logic         i1_last, i1_valid, i1_ready;
  logic         o_last, o_valid, o_ready, s;

  int n_checks = 0;
  int n_pass   = 0;

  arb_mux2_stream #(.WIDTH(W)) dut (
    .CLK         (clk),
    .ASYNCRESETN (rst_n),
    .I0_data     (i0_data),
    .I0_last     (i0_last),
    .I0_valid    (i0_valid),
    .I0_ready    (i0_ready),
    .I1_data     (i1_data),
    .I1_last     (i1_last),
    .I1_valid    (i1_valid),
    .I1_ready    (i1_ready),
    .O_data      (o_data),
    .O_last      (o_last),
    .O_valid     (o_valid),
    .O_ready     (o_ready),
    .S           (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    i0_data  = 4'hA; i0_last = 1'b1; i0_valid = 1'b1;
    i1_data  = 4'h5; i1_last = 1'b1; i1_valid = 1'b1;
    o_ready  = 1'b1;

    // Reset held with both inputs requesting.
    repeat (3) tick();
    check_eq("rst_o_valid", o_valid, 0);
    check_eq("rst_o_data", o_data, 0);
    check_eq("rst_o_last", o_last, 0);
    check_eq("rst_i0_ready", i0_ready, 0);
    check_eq("rst_i1_ready", i1_ready, 0);
    check_eq("rst_s", s, 0);

    // Release: tie goes to input 0 first, then alternates every beat.
    rst_n = 1'b1;
    #1;
    check_eq("rel_i0_ready", i0_ready, 1);
    check_eq("rel_i1_ready", i1_ready, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("alt_o_valid", o_valid, 1);
      check_eq("alt_o_data", o_data, (k % 2 == 0) ? 32'hA : 32'h5);
      check_eq("alt_o_last", o_last, 1);
    end

    // Packet lock: I0 sends 1,2,3 while I1 waits with 9.
    i0_data = 4'h1; i0_last = 1'b0;
    i1_data = 4'h9; i1_last = 1'b1;
    #1;
    check_eq("lock_s_start", s, 0);
    check_eq("lock_i1_ready_b1", i1_ready, 0);
    tick();
    check_eq("lock_beat1", o_data, 1);
    check_eq("lock_beat1_last", o_last, 0);
    i0_data = 4'h2;
    #1;
    check_eq("lock_i1_ready_b2", i1_ready, 0);
    check_eq("lock_i0_ready_b2", i0_ready, 1);
    tick();
    check_eq("lock_beat2", o_data, 2);
    i0_data = 4'h3; i0_last = 1'b1;
    #1;
    check_eq("lock_i1_ready_b3", i1_ready, 0);
    tick();
    check_eq("lock_beat3", o_data, 3);
    check_eq("lock_beat3_last", o_last, 1);
    i0_valid = 1'b0;
    #1;
    check_eq("lock_i1_ready_after", i1_ready, 1);
    check_eq("lock_s_after", s, 1);
    tick();
    check_eq("lock_beat4", o_data, 9);
    check_eq("lock_beat4_last", o_last, 1);
    i1_valid = 1'b0;

    // Backpressure: output full and stalled for 4 cycles.
    i0_valid = 1'b1; i0_data = 4'h7; i0_last = 1'b1;
    o_ready  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("bp_o_valid", o_valid, 1);
      check_eq("bp_o_data", o_data, 9);
      check_eq("bp_i0_ready", i0_ready, 0);
      check_eq("bp_i1_ready", i1_ready, 0);
      tick();
    end
    o_ready = 1'b1;
    #1;
    check_eq("bp_release_i0_ready", i0_ready, 1);
    tick();
    check_eq("bp_release_o_data", o_data, 7);
    check_eq("bp_release_o_valid", o_valid, 1);

    // Reset during an I1 packet after two beats.
    i0_valid = 1'b0;
    i1_valid = 1'b1; i1_data = 4'h1; i1_last = 1'b0;
    tick();
    check_eq("mid_beat1", o_data, 1);
    i1_data = 4'h2;
    tick();
    check_eq("mid_beat2", o_data, 2);
    check_eq("mid_s_locked", s, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_o_valid", o_valid, 0);
    check_eq("mid_rst_o_data", o_data, 0);
    check_eq("mid_rst_i1_ready", i1_ready, 0);
    i0_valid = 1'b1; i0_data = 4'hC; i0_last = 1'b1;
    i1_data  = 4'h3; i1_last = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("mid_rel_s", s, 0);
    check_eq("mid_rel_i0_ready", i0_ready, 1);
    tick();
    check_eq("mid_rel_o_data", o_data, 32'hC);

    // Idle select hold after an I1 packet drains.
    i0_valid = 1'b0;
    i1_data  = 4'h6;
    tick();
    check_eq("hold_o_data", o_data, 6);
    i1_valid = 1'b0;
    #1;
    check_eq("hold_s_idle", s, 1);
    check_eq("hold_o_valid_pre", o_valid, 1);
    tick();
    check_eq("hold_o_valid_drain", o_valid, 0);
    check_eq("hold_s_drain", s, 1);
    tick();
    check_eq("hold_s_later", s, 1);
    check_eq("hold_o_valid_later", o_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
